// File: rtl/neuron_seq_ctrl_pkg.sv
// neuron_ctrl_pkg: sequencer state encoding and default sizing shared by the neuron sequencer files
package neuron_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, EMIT, DONE} state_t;
   function automatic int cnt_w(input int beats, input int lat);
      return $clog2((beats > lat ? beats : lat) + 1);
   endfunction
   localparam int DEF_BEATS = 4;
   localparam int DEF_MAC_LAT = 2;
   localparam int DEF_NEURONS = 10;
   localparam int BEAT_CNT_W = cnt_w(DEF_BEATS, DEF_MAC_LAT);
   localparam int NEURON_W = $clog2(DEF_NEURONS);
endpackage

// File: rtl/neuron_seq_ctrl_if.sv
// neuron_seq_ctrl_if: valid/ready result stream carrying neuron index and sigmoid output
interface neuron_seq_ctrl_if
   import neuron_ctrl_pkg::*;
#(
   parameter int IDX_W = NEURON_W
);
   logic out_valid;
   logic out_ready;
   logic [IDX_W-1:0] out_idx;
   logic [7:0] out_data;
   modport master (output out_valid, out_idx, out_data, input out_ready);
   modport slave (input out_valid, out_idx, out_data, output out_ready);
endinterface

// File: rtl/neuron_seq_ctrl_beat_cnt.sv
// neuron_beat_cnt: loadable down-counter that stops at zero and flags its terminal count
module neuron_beat_cnt #(
   parameter int W = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ld,
   input  logic [W-1:0] ld_val,
   output logic [W-1:0] cnt,
   output logic tc
);
   assign tc = cnt == '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (ld) cnt <= ld_val;
      else if (!tc) cnt <= cnt - 1'b1;
   end
endmodule

// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: walks NEURONS neurons through one MAC/sigmoid datapath and streams each result out
module neuron_seq_ctrl
   import neuron_ctrl_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int BEATS = DEF_BEATS,
   parameter int NEURONS = DEF_NEURONS,
   parameter int ADDR_W = 6,
   parameter int MAC_LAT = DEF_MAC_LAT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   input  logic [ADDR_W-1:0] img_base,
   output logic busy,
   output logic done,
   output logic rd_en,
   output logic [ADDR_W-1:0] p_addr,
   output logic [ADDR_W-1:0] w_addr,
   output logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] p_rdata,
   input  logic [DATA_W-1:0] w_rdata,
   input  logic [7:0] b_rdata,
   output logic mac_clr,
   output logic [DATA_W-1:0] mac_p,
   output logic [DATA_W-1:0] mac_w,
   output logic [7:0] mac_b,
   input  logic [7:0] mac_dout,
   neuron_seq_ctrl_if.master res
);
   localparam int CW = cnt_w(BEATS, MAC_LAT);
   localparam int NW = NEURONS > 1 ? $clog2(NEURONS) : 1;
   state_t state, nxt;
   logic [ADDR_W-1:0] base;
   logic [NW-1:0] neuron, idx_q;
   logic [7:0] data_q;
   logic [CW-1:0] cnt, ld_val;
   logic ld, tc, last;
   int bi;
   neuron_beat_cnt #(.W(CW)) u_cnt (.clk, .rst_n, .ld, .ld_val, .cnt, .tc);
   assign last = neuron == NW'(NEURONS - 1);
   always_comb begin
      nxt = state;
      ld = 1'b0;
      ld_val = '0;
      case (state)
         IDLE: if (start) nxt = LOAD;
         LOAD: begin
            nxt = RUN;
            ld = 1'b1;
            ld_val = CW'(BEATS - 1);
         end
         RUN: if (tc) begin
            nxt = DRAIN;
            ld = 1'b1;
            ld_val = CW'(MAC_LAT - 1);
         end
         DRAIN: if (tc) nxt = EMIT;
         EMIT: if (res.out_ready) nxt = last ? DONE : LOAD;
         default: nxt = IDLE;
      endcase
      if (abort) nxt = IDLE;
   end
   // RUN prefetches one beat ahead, so its read index is beat+1 and the final RUN cycle reads nothing
   assign bi = state == RUN ? BEATS - int'(cnt) : 0;
   assign busy = state inside {LOAD, RUN, DRAIN, EMIT};
   assign done = state == DONE;
   assign mac_clr = !(state inside {RUN, DRAIN});
   assign rd_en = state == LOAD || (state == RUN && !tc);
   assign p_addr = ADDR_W'(int'(base) + bi);
   assign w_addr = ADDR_W'(int'(neuron) * BEATS + bi);
   assign b_addr = ADDR_W'(neuron);
   assign res.out_valid = state == EMIT;
   assign res.out_idx = idx_q;
   assign res.out_data = data_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         base <= '0;
         neuron <= '0;
         mac_p <= '0;
         mac_w <= '0;
         mac_b <= '0;
         idx_q <= '0;
         data_q <= '0;
      end else begin
         state <= nxt;
         mac_p <= state == RUN ? p_rdata : '0;
         mac_w <= state == RUN ? w_rdata : '0;
         if (state == IDLE && nxt == LOAD) begin
            base <= img_base;
            neuron <= '0;
         end
         if (state == EMIT && nxt == LOAD) neuron <= neuron + 1'b1;
         if (state == RUN && cnt == CW'(BEATS - 1)) mac_b <= b_rdata;
         if (state == DRAIN && tc) begin
            data_q <= mac_dout;
            idx_q <= neuron;
         end
      end
   end
endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// tb_neuron_seq_ctrl: random RAM contents and image bases against an arithmetic neuron reference model
module tb_neuron_seq_ctrl;
   logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, start2 = 1'b0;
   logic [5:0] img_base = '0;
   logic busy, done, rd_en, mac_clr;
   logic [5:0] p_addr, w_addr, b_addr;
   logic [127:0] p_rdata = '0, w_rdata = '0, mac_p, mac_w;
   logic [7:0] b_rdata = '0, mac_b, mac_dout;
   logic busy2, done2, rd_en2, clr2;
   logic [5:0] pa2, wa2, ba2;
   logic [127:0] mp2, mw2;
   logic [7:0] mb2;
   logic [127:0] pix [64];
   logic [127:0] wgt [64];
   logic [7:0] bias [64];
   int acc = 0, cyc = 0, checks = 0, failures = 0;
   int n_res, done_c, e_cyc, stall_bad, stalled;
   int ridx [16];
   int rcyc [16];
   logic [7:0] rdat [16];
   logic [7:0] hold_dat;
   neuron_seq_ctrl_if #(.IDX_W(4)) ifc ();
   neuron_seq_ctrl_if #(.IDX_W(4)) r2 ();
   neuron_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .img_base(img_base),
      .busy(busy), .done(done), .rd_en(rd_en), .p_addr(p_addr), .w_addr(w_addr), .b_addr(b_addr),
      .p_rdata(p_rdata), .w_rdata(w_rdata), .b_rdata(b_rdata), .mac_clr(mac_clr),
      .mac_p(mac_p), .mac_w(mac_w), .mac_b(mac_b), .mac_dout(mac_dout), .res(ifc)
   );
   neuron_seq_ctrl #(.NEURONS(16)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .img_base(6'd0),
      .busy(busy2), .done(done2), .rd_en(rd_en2), .p_addr(pa2), .w_addr(wa2), .b_addr(ba2),
      .p_rdata(128'd0), .w_rdata(128'd0), .b_rdata(8'd0), .mac_clr(clr2),
      .mac_p(mp2), .mac_w(mw2), .mac_b(mb2), .mac_dout(8'd0), .res(r2)
   );
   assign r2.out_ready = 1'b1;
   always #5 clk = ~clk;
   function automatic int dot(input logic [127:0] a, input logic [127:0] b);
      int s = 0;
      for (int l = 0; l < 16; l++) s += int'(a[l*8 +: 8]) * int'(b[l*8 +: 8]);
      return s;
   endfunction
   function automatic logic [7:0] mixf(input int s, input logic [7:0] b);
      return 8'(s >> 5) ^ 8'(s >> 13) ^ b;
   endfunction
   function automatic logic [7:0] model(input int base, input int n);
      int s = 0;
      for (int k = 0; k < 4; k++) s += dot(pix[(base + k) % 64], wgt[(n * 4 + k) % 64]);
      return mixf(s, bias[n]);
   endfunction
   // synchronous-read RAMs and a MAC that accumulates lane dot products while not cleared
   always @(posedge clk) begin
      cyc <= cyc + 1;
      acc <= mac_clr ? 0 : acc + dot(mac_p, mac_w);
      if (rd_en) begin
         p_rdata <= pix[p_addr];
         w_rdata <= wgt[w_addr];
         b_rdata <= bias[b_addr];
      end
   end
   assign mac_dout = mixf(acc, mac_b);
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic run_image(input logic [5:0] base, input int stall_idx, input int stall_n,
                            input int poke, input int poke_done, input int abort_at);
      n_res = 0;
      done_c = -1;
      stall_bad = 0;
      stalled = 0;
      img_base = base;
      start = 1'b1;
      ifc.out_ready = 1'b1;
      tick();
      start = 1'b0;
      e_cyc = cyc;
      for (int k = 0; k < 400 && done_c < 0; k++) begin
         start = (cyc - e_cyc) == poke;
         if ((cyc - e_cyc) == abort_at) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            start = 1'b0;
            return;
         end
         if (ifc.out_valid) begin
            if (stalled > 0 && int'(ifc.out_idx) == stall_idx && ifc.out_data !== hold_dat) stall_bad++;
            if (rd_en) stall_bad++;
            if (int'(ifc.out_idx) == stall_idx && stalled < stall_n) begin
               hold_dat = ifc.out_data;
               stalled++;
               ifc.out_ready = 1'b0;
            end else begin
               if (n_res < 16) begin
                  ridx[n_res] = int'(ifc.out_idx);
                  rdat[n_res] = ifc.out_data;
                  rcyc[n_res] = cyc;
               end
               n_res++;
               ifc.out_ready = 1'b1;
            end
         end
         if (done) begin
            done_c = cyc;
            start = poke_done != 0;
         end
         tick();
      end
      start = 1'b0;
   endtask
   task automatic test_reset();
      #1 rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({busy, done, rd_en, ifc.out_valid, mac_clr} !== 5'b00001) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=00001", {busy, done, rd_en, ifc.out_valid, mac_clr});
      end
      checks++;
      if ({p_addr, w_addr, b_addr} !== 18'd0) begin
         failures++;
         $display("FAIL reset_addr got=%h exp=0", {p_addr, w_addr, b_addr});
      end
      checks++;
      if ({mac_p, mac_w, mac_b} !== '0) begin
         failures++;
         $display("FAIL reset_mac got=%h/%h/%h exp=0", mac_p, mac_w, mac_b);
      end
      checks++;
      if ({ifc.out_idx, ifc.out_data} !== 12'd0) begin
         failures++;
         $display("FAIL reset_out got=%h exp=0", {ifc.out_idx, ifc.out_data});
      end
      rst_n = 1'b1;
      tick();
   endtask
   task automatic test_golden();
      logic [5:0] base;
      int bad = 0;
      base = 6'($urandom_range(0, 63));
      run_image(base, -1, 0, -1, 0, -1);
      checks++;
      if (n_res != 10) begin
         failures++;
         $display("FAIL golden_count got=%0d exp=10", n_res);
      end
      checks++;
      if (rcyc[0] - e_cyc != 7) begin
         failures++;
         $display("FAIL golden_first_latency got=%0d exp=7", rcyc[0] - e_cyc);
      end
      for (int i = 0; i < 10 && i < n_res; i++) begin
         checks++;
         if (ridx[i] != i || rdat[i] !== model(int'(base), i)) begin
            failures++;
            $display("FAIL golden_result%0d got=idx%0d/%h exp=idx%0d/%h", i, ridx[i], rdat[i], i, model(int'(base), i));
         end
         if (i > 0 && rcyc[i] - rcyc[i-1] != 8) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL golden_spacing got=%0d_bad exp=0_bad", bad);
      end
      checks++;
      if (done_c != rcyc[9] + 1) begin
         failures++;
         $display("FAIL golden_done got=%0d exp=%0d", done_c, rcyc[9] + 1);
      end
   endtask
   task automatic test_backpressure();
      logic [5:0] base;
      int bad = 0;
      base = 6'($urandom_range(0, 63));
      run_image(base, 3, 5, -1, 0, -1);
      for (int i = 0; i < 10; i++) if (ridx[i] != i || rdat[i] !== model(int'(base), i)) bad++;
      checks++;
      if (n_res != 10 || bad != 0) begin
         failures++;
         $display("FAIL bp_results got=%0d_res/%0d_bad exp=10/0", n_res, bad);
      end
      checks++;
      if (stalled != 5 || stall_bad != 0) begin
         failures++;
         $display("FAIL bp_hold got=%0d_stalls/%0d_unstable exp=5/0", stalled, stall_bad);
      end
      checks++;
      if (rcyc[3] - rcyc[2] != 13 || rcyc[4] - rcyc[3] != 8) begin
         failures++;
         $display("FAIL bp_timing got=%0d,%0d exp=13,8", rcyc[3] - rcyc[2], rcyc[4] - rcyc[3]);
      end
   endtask
   task automatic test_start_ignored();
      logic [5:0] base;
      int bad = 0;
      base = 6'($urandom_range(0, 63));
      run_image(base, -1, 0, 17, 1, -1);
      for (int i = 0; i < 10; i++) begin
         if (ridx[i] != i || rdat[i] !== model(int'(base), i)) bad++;
         if (i > 0 && rcyc[i] - rcyc[i-1] != 8) bad++;
      end
      checks++;
      if (n_res != 10 || bad != 0 || done_c != rcyc[9] + 1) begin
         failures++;
         $display("FAIL start_busy got=%0d_res/%0d_bad/done%0d exp=10/0/done%0d", n_res, bad, done_c, rcyc[9] + 1);
      end
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
         failures++;
         $display("FAIL start_in_done got=busy%b/rd%b exp=busy0/rd0", busy, rd_en);
      end
      base = 6'($urandom_range(0, 63));
      run_image(base, -1, 0, -1, 0, -1);
      bad = 0;
      for (int i = 0; i < 10; i++) if (ridx[i] != i || rdat[i] !== model(int'(base), i)) bad++;
      checks++;
      if (n_res != 10 || bad != 0 || rcyc[0] - e_cyc != 7) begin
         failures++;
         $display("FAIL start_after_done got=%0d_res/%0d_bad/lat%0d exp=10/0/lat7", n_res, bad, rcyc[0] - e_cyc);
      end
   endtask
   task automatic test_abort();
      logic [5:0] base;
      int bad = 0;
      base = 6'($urandom_range(0, 63));
      run_image(base, -1, 0, -1, 0, 42);
      checks++;
      if (n_res != 5) begin
         failures++;
         $display("FAIL abort_prior got=%0d exp=5", n_res);
      end
      checks++;
      if ({mac_clr, rd_en, busy, ifc.out_valid} !== 4'b1000) begin
         failures++;
         $display("FAIL abort_state got=%b exp=1000", {mac_clr, rd_en, busy, ifc.out_valid});
      end
      for (int k = 0; k < 20; k++) begin
         if (ifc.out_valid || done || busy) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL abort_quiet got=%0d exp=0", bad);
      end
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_beats_start got=%b exp=0", busy);
      end
      base = 6'($urandom_range(0, 63));
      run_image(base, -1, 0, -1, 0, -1);
      bad = 0;
      for (int i = 0; i < 10; i++) if (ridx[i] != i || rdat[i] !== model(int'(base), i)) bad++;
      checks++;
      if (n_res != 10 || bad != 0 || done_c < 0) begin
         failures++;
         $display("FAIL abort_rerun got=%0d_res/%0d_bad/done%0d exp=10/0/done", n_res, bad, done_c);
      end
   endtask
   task automatic test_addr_wrap();
      logic [5:0] pq [$];
      logic [5:0] wq [$];
      img_base = 6'd62;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (rd_en) begin
            pq.push_back(p_addr);
            wq.push_back(w_addr);
         end
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (pq.size() != 4) begin
         failures++;
         $display("FAIL wrap_reads got=%0d exp=4", pq.size());
      end
      for (int k = 0; k < 4 && k < pq.size(); k++) begin
         checks++;
         if (pq[k] !== 6'(62 + k) || wq[k] !== 6'(k)) begin
            failures++;
            $display("FAIL wrap_addr%0d got=p%0d/w%0d exp=p%0d/w%0d", k, pq[k], wq[k], 6'(62 + k), k);
         end
      end
      wq.delete();
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int k = 0; k < 300 && !done2; k++) begin
         if (rd_en2 && ba2 == 6'd15) wq.push_back(wa2);
         tick();
      end
      checks++;
      if (wq.size() != 4 || !done2) begin
         failures++;
         $display("FAIL w15_reads got=%0d/done%b exp=4/done1", wq.size(), done2);
      end
      for (int k = 0; k < 4 && k < wq.size(); k++) begin
         checks++;
         if (wq[k] !== 6'(60 + k)) begin
            failures++;
            $display("FAIL w15_addr%0d got=%0d exp=%0d", k, wq[k], 60 + k);
         end
      end
      tick();
   endtask
   task automatic test_reset_mid();
      int bad = 0;
      img_base = 6'($urandom_range(0, 63));
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      checks++;
      if (mac_clr !== 1'b0 || busy !== 1'b1 || rd_en !== 1'b0) begin
         failures++;
         $display("FAIL drain_pre got=clr%b/busy%b/rd%b exp=clr0/busy1/rd0", mac_clr, busy, rd_en);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, rd_en, ifc.out_valid, mac_clr} !== 5'b00001 || {p_addr, w_addr, b_addr} !== 18'd0) begin
         failures++;
         $display("FAIL midreset_ctrl got=%b/%h exp=00001/0", {busy, done, rd_en, ifc.out_valid, mac_clr}, {p_addr, w_addr, b_addr});
      end
      checks++;
      if ({mac_p, mac_w, mac_b} !== '0 || {ifc.out_idx, ifc.out_data} !== 12'd0) begin
         failures++;
         $display("FAIL midreset_data got=%h/%h exp=0/0", mac_b, {ifc.out_idx, ifc.out_data});
      end
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (ifc.out_valid || busy || done) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL midreset_after got=%0d exp=0", bad);
      end
   endtask
   initial begin
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         pix[i] = {$urandom, $urandom, $urandom, $urandom};
         wgt[i] = {$urandom, $urandom, $urandom, $urandom};
         bias[i] = 8'($urandom);
      end
      test_reset();
      test_golden();
      test_backpressure();
      test_start_ignored();
      test_abort();
      test_addr_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
